// File: rtl/fp16_pkg.sv
// Shared FP16 field definitions, constants, operand classes and divider FSM states.
package fp16_pkg;

  localparam int unsigned FP_W      = 16;
  localparam int unsigned EXP_W     = 5;
  localparam int unsigned FRAC_W    = 10;
  localparam int unsigned MANT_W    = FRAC_W + 1;
  localparam int unsigned EXP_BIAS  = 15;
  localparam int unsigned E_W       = 7;
  localparam int unsigned Q_W       = 14;
  localparam int unsigned DIV_ITERS = 14;
  localparam int unsigned CNT_W     = 4;

  localparam logic [FP_W-1:0] QNAN    = 16'h7E00;
  localparam logic [FP_W-2:0] INF_MAG = 15'h7C00;

  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp_class_e;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_ROUND, S_OUT} state_e;

  // Subnormal inputs collapse to ZERO (denormals-are-zero).
  function automatic fp_class_e classify(input logic [FP_W-1:0] x);
    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
    e = x[FP_W-2 -: EXP_W];
    f = x[FRAC_W-1:0];
    if (e == '0) return ZERO;
    if (e == '1) return (f == '0) ? INF : NAN;
    return NORMAL;
  endfunction

endpackage

// File: rtl/fp16_mant_div_iter.sv
// Radix-2 restoring mantissa divider: one quotient bit per cycle, 14 bits MSB-first.
module fp16_mant_div_iter
  import fp16_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [MANT_W-1:0] dividend,
  input  logic [MANT_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [Q_W-1:0]    q,
  output logic              rem_nz
);

  logic [MANT_W:0]   rem;
  logic [MANT_W-1:0] dvs;
  logic [CNT_W-1:0]  cnt;
  logic              ge_c;
  logic [MANT_W-1:0] diff_c;

  // After a restoring step the remainder is below the divisor, so it fits MANT_W bits.
  assign ge_c   = (rem >= {1'b0, dvs});
  assign diff_c = ge_c ? MANT_W'(rem - {1'b0, dvs}) : rem[MANT_W-1:0];

  // done flags the cycle whose closing edge retires the final quotient bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      q      <= '0;
      rem_nz <= 1'b0;
    end else if (start) begin
      rem    <= {1'b0, dividend};
      dvs    <= divisor;
      cnt    <= '0;
      busy   <= 1'b1;
      done   <= 1'b0;
      q      <= '0;
      rem_nz <= 1'b0;
    end else if (busy) begin
      rem    <= {diff_c, 1'b0};
      q      <= {q[Q_W-2:0], ge_c};
      rem_nz <= |diff_c;
      cnt    <= cnt + CNT_W'(1);
      done   <= (cnt == CNT_W'(DIV_ITERS - 2));
      if (cnt == CNT_W'(DIV_ITERS - 1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/fp16_divider.sv
// Iterative FP16 divider a / b: handshake FSM, special-case handling and RNE round/pack.
module fp16_divider
  import fp16_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FP_W-1:0] out,
  output logic            div_by_zero
);

  state_e                 state;
  fp_class_e              cls_a;
  fp_class_e              cls_b;
  logic                   sign_q;
  logic signed [E_W-1:0]  exp_q;

  logic                   start_c;
  logic signed [E_W-1:0]  exp_in_c;
  logic                   div_busy;
  logic                   div_done;
  logic [Q_W-1:0]         div_q;
  logic                   div_rem_nz;

  logic [FRAC_W-1:0]      frac_c;
  logic                   g_c;
  logic                   s_c;
  logic [FRAC_W:0]        frac_rnd_c;
  logic signed [E_W-1:0]  e_norm_c;
  logic signed [E_W-1:0]  e_fin_c;
  logic [FP_W-1:0]        res_c;
  logic                   dbz_c;

  assign start_c  = (state == S_IDLE) && in_valid;
  assign exp_in_c = E_W'({2'b00, a[FP_W-2 -: EXP_W]}) - E_W'({2'b00, b[FP_W-2 -: EXP_W]})
                  + E_W'(EXP_BIAS);

  fp16_mant_div_iter u_mant_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_c),
    .dividend ({1'b1, a[FRAC_W-1:0]}),
    .divisor  ({1'b1, b[FRAC_W-1:0]}),
    .busy     (div_busy),
    .done     (div_done),
    .q        (div_q),
    .rem_nz   (div_rem_nz)
  );

  // Normalize, round to nearest even, then apply the special-class overrides.
  always_comb begin
    frac_c   = '0;
    g_c      = 1'b0;
    s_c      = 1'b0;
    e_norm_c = exp_q;
    if (div_q[Q_W-1]) begin
      frac_c = div_q[Q_W-2:3];
      g_c    = div_q[2];
      s_c    = (|div_q[1:0]) | div_rem_nz;
    end else begin
      frac_c   = div_q[Q_W-3:2];
      g_c      = div_q[1];
      s_c      = div_q[0] | div_rem_nz;
      e_norm_c = exp_q - E_W'(1);
    end
    // Hidden bit is always set, so a carry out of the fraction means mantissa overflow.
    frac_rnd_c = {1'b0, frac_c} + (FRAC_W + 1)'(g_c & (s_c | frac_c[0]));
    e_fin_c    = frac_rnd_c[FRAC_W] ? (e_norm_c + E_W'(1)) : e_norm_c;

    dbz_c = 1'b0;
    if (cls_a == NAN || cls_b == NAN || (cls_a == ZERO && cls_b == ZERO) ||
        (cls_a == INF && cls_b == INF)) begin
      res_c = QNAN;
    end else if (cls_b == ZERO) begin
      res_c = {sign_q, INF_MAG};
      dbz_c = 1'b1;
    end else if (cls_a == INF) begin
      res_c = {sign_q, INF_MAG};
    end else if (cls_a == ZERO || cls_b == INF) begin
      res_c = {sign_q, (FP_W-1)'(0)};
    end else if (e_fin_c >= E_W'(31)) begin
      res_c = {sign_q, INF_MAG};
    end else if (e_fin_c <= E_W'(0)) begin
      res_c = {sign_q, (FP_W-1)'(0)};
    end else begin
      res_c = {sign_q, e_fin_c[EXP_W-1:0], frac_rnd_c[FRAC_W-1:0]};
    end
  end

  // Handshake FSM with registered in_ready/out_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out         <= '0;
      div_by_zero <= 1'b0;
      cls_a       <= ZERO;
      cls_b       <= ZERO;
      sign_q      <= 1'b0;
      exp_q       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            cls_a    <= classify(a);
            cls_b    <= classify(b);
            sign_q   <= a[FP_W-1] ^ b[FP_W-1];
            exp_q    <= exp_in_c;
            in_ready <= 1'b0;
            state    <= S_DIV;
          end
        end
        S_DIV: begin
          if (div_done || !div_busy) state <= S_ROUND;
        end
        S_ROUND: begin
          out         <= res_c;
          div_by_zero <= dbz_c;
          out_valid   <= 1'b1;
          state       <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_divider.sv
// Scoreboard bench for fp16_divider: directed vectors, latency, backpressure and mid-run reset.
module tb_fp16_divider;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dut_out;
  logic        dbz;

  int checks = 0;
  int errors = 0;
  int pcyc   = 0;

  typedef struct packed {
    int          id;
    logic [15:0] res;
    logic        dbz;
  } exp_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        dbz;
  } vec_t;

  exp_t sb[$];
  int   acc_q[$];

  logic        prev_valid = 1'b0;
  logic        prev_hs    = 1'b0;
  logic [15:0] held_out   = '0;
  logic        held_dbz   = 1'b0;

  localparam int NVEC = 16;
  localparam vec_t VEC [NVEC] = '{
    '{16'h4000, 16'h3C00, 16'h4000, 1'b0},
    '{16'h3C00, 16'h4200, 16'h3555, 1'b0},
    '{16'h3C00, 16'h3C01, 16'h3BFE, 1'b0},
    '{16'h3C00, 16'h0000, 16'h7C00, 1'b1},
    '{16'hBC00, 16'h0000, 16'hFC00, 1'b1},
    '{16'h0000, 16'h0000, 16'h7E00, 1'b0},
    '{16'h7C00, 16'h7C00, 16'h7E00, 1'b0},
    '{16'h7E01, 16'h3C00, 16'h7E00, 1'b0},
    '{16'h3C00, 16'h7C00, 16'h0000, 1'b0},
    '{16'h7BFF, 16'h0400, 16'h7C00, 1'b0},
    '{16'h0400, 16'h7BFF, 16'h0000, 1'b0},
    '{16'h8400, 16'h7BFF, 16'h8000, 1'b0},
    '{16'h0200, 16'h3C00, 16'h0000, 1'b0},
    '{16'hC000, 16'h4000, 16'hBC00, 1'b0},
    '{16'h7C00, 16'hC000, 16'hFC00, 1'b0},
    '{16'h0000, 16'h4000, 16'h0000, 1'b0}
  };

  fp16_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out         (dut_out),
    .div_by_zero (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) pcyc <= pcyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, expv);
    end
  endtask

  // Monitor: sampled on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_q.delete();
      prev_valid <= 1'b0;
      prev_hs    <= 1'b0;
    end else begin
      if (prev_hs) chk("in_ready_after_handshake", 32'(in_ready), 32'd1);
      if (in_valid && in_ready) acc_q.push_back(pcyc + 1);
      if (out_valid && !prev_valid) begin
        chk("result_has_accept", 32'(acc_q.size() != 0), 32'd1);
        if (acc_q.size() != 0) chk("latency", 32'(pcyc - acc_q.pop_front()), 32'd15);
        held_out <= dut_out;
        held_dbz <= dbz;
      end
      if (out_valid && !out_ready) begin
        chk("in_ready_while_stalled", 32'(in_ready), 32'd0);
        if (prev_valid) begin
          chk("out_held", 32'(dut_out), 32'(held_out));
          chk("dbz_held", 32'(dbz), 32'(held_dbz));
        end
      end
      if (out_valid && out_ready) begin
        chk("result_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          chk($sformatf("out_vec%0d", sb[0].id), 32'(dut_out), 32'(sb[0].res));
          chk($sformatf("dbz_vec%0d", sb[0].id), 32'(dbz), 32'(sb[0].dbz));
          void'(sb.pop_front());
        end
      end
      prev_valid <= out_valid;
      prev_hs    <= out_valid && out_ready;
    end
  end

  // Present one operand pair; called 2 time units after a rising edge.
  task automatic issue(input int id, input logic [15:0] ta, input logic [15:0] tb,
                       input logic [15:0] eo, input logic ed, input bit push);
    exp_t e;
    int   g;
    g = 0;
    while (!in_ready && g < 100) begin
      @(posedge clk); #2;
      g++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout vec%0d in_ready %b expected 1", id, in_ready);
    end else begin
      in_valid = 1'b1;
      a        = ta;
      b        = tb;
      if (push) begin
        e = '{id: id, res: eo, dbz: ed};
        sb.push_back(e);
      end
      @(posedge clk); #2;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 200) begin
      @(posedge clk); #2;
      g++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending %0d expected 0", sb.size());
    end
  endtask

  initial begin
    int g;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out", 32'(dut_out), 32'd0);
    chk("reset_dbz", 32'(dbz), 32'd0);

    for (int i = 0; i < NVEC; i++) issue(i, VEC[i].a, VEC[i].b, VEC[i].res, VEC[i].dbz, 1'b1);
    drain();

    // Backpressure: consumer stalls for 5 cycles once the result appears.
    out_ready = 1'b0;
    issue(100, 16'h4200, 16'h3C00, 16'h4200, 1'b0, 1'b1);
    g = 0;
    while (!out_valid && g < 40) begin
      @(posedge clk); #2;
      g++;
    end
    chk("bp_out_valid_seen", 32'(out_valid), 32'd1);
    repeat (5) @(posedge clk);
    #2;
    out_ready = 1'b1;
    issue(101, 16'h4500, 16'h4000, 16'h4100, 1'b0, 1'b1);
    issue(102, 16'h3C00, 16'h4200, 16'h3555, 1'b0, 1'b1);
    drain();

    // Reset during DIV: the aborted operation must never produce a result.
    issue(200, 16'h3C00, 16'h4200, 16'h0000, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    issue(201, 16'h4400, 16'h4000, 16'h4000, 1'b0, 1'b1);
    drain();
    repeat (25) @(posedge clk);
    #2;
    chk("no_extra_results", 32'(sb.size()), 32'd0);
    chk("final_in_ready", 32'(in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time %0t expected completion", $time);
    $fatal(1);
  end

endmodule
